// File: rtl/core_pkg.sv
// Shared core encodings used by the write-back path and, later, the load/store unit.
//   wb_sel encodings  : WB_ALU, WB_MEM, WB_PC4 (2'b11 is reserved)
//   load funct3 codes : F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
//   wb_stage states   : WB_IDLE, WB_WAIT_MEM
package core_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/halfword/word addressed by
// offset out of a word-aligned memory read and sign/zero-extends it.
//   mem_rdata  : word-aligned read data
//   offset     : byte offset within the word (address[1:0])
//   funct3     : load type; unsupported codes behave as LW
//   data       : formatted value
//   misaligned : access does not fit its natural alignment
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    // Halfword lanes only exist at offsets 0 and 2; offset[0] flags misalignment.
    half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    data       = mem_rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = offset[0];
      end
      default: begin
        // LW and the unsupported encodings
        data       = mem_rdata;
        misaligned = |offset;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage. Accepts one retired instruction per handshake and issues a
// single-cycle registered register-file write. Non-loads write the cycle after
// acceptance; loads park in WB_WAIT_MEM until the data-memory response arrives.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : upstream handshake
//   alu_result, pc_plus4, rd, reg_write, wb_sel, funct3 : retired instruction
//   mem_rvalid, mem_rdata : data-memory read response
//   rf_we, rf_waddr, rf_wdata : register-file write port (rf_we is a pulse)
//   misaligned            : pulse when a load is dropped for misalignment
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic [1:0]            wb_sel,
  input  logic [2:0]            funct3,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  misaligned
);

  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       pc_plus4;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic [1:0]            wb_sel;
    logic [2:0]            funct3;
  } wb_req_t;

  wb_state_e       state;
  wb_req_t         req_in, cap;
  logic            accept;
  logic [XLEN-1:0] ld_data;
  logic            ld_mis;

  assign req_in = '{alu_result: alu_result, pc_plus4: pc_plus4, rd: rd,
                    reg_write: reg_write, wb_sel: wb_sel, funct3: funct3};

  assign in_ready = (state == WB_IDLE);
  assign accept   = in_valid && in_ready;

  // Writes to x0, non-writing instructions and the reserved select are squashed.
  function automatic logic write_ok(input wb_req_t r);
    return r.reg_write && (r.rd != '0) && (r.wb_sel != 2'b11);
  endfunction

  load_align #(.XLEN(XLEN)) u_align (
    .mem_rdata  (mem_rdata),
    .offset     (cap.alu_result[1:0]),
    .funct3     (cap.funct3),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  // Captured fields kept for debug visibility but not needed by the load path.
  logic unused_cap;
  assign unused_cap = ^{cap.pc_plus4, cap.alu_result[XLEN-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WB_IDLE;
      cap        <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      misaligned <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (accept) begin
            cap <= req_in;
            if (wb_sel == WB_MEM) begin
              state <= WB_WAIT_MEM;
            end else begin
              rf_we    <= write_ok(req_in);
              rf_waddr <= rd;
              rf_wdata <= (wb_sel == WB_PC4) ? pc_plus4 : alu_result;
            end
          end
        end
        WB_WAIT_MEM: begin
          if (mem_rvalid) begin
            state <= WB_IDLE;
            if (ld_mis) begin
              // Response consumed, write dropped; port values stay put.
              misaligned <= 1'b1;
            end else begin
              rf_we    <= write_ok(cap);
              rf_waddr <= cap.rd;
              rf_wdata <= ld_data;
            end
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result, pc_plus4, mem_rdata, rf_wdata;
  logic [4:0]  rd, rf_waddr;
  logic        reg_write, mem_rvalid, rf_we, misaligned;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;

  int errors = 0;
  int checks = 0;

  wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .rd(rd), .reg_write(reg_write),
    .wb_sel(wb_sel), .funct3(funct3), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Load result from the architectural rule: shift the addressed bytes down,
  // mask to the access size, then extend.
  function automatic logic [31:0] ld_fmt(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] w, output bit mis);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'b000: begin mis = 0;          return {{24{sh[7]}}, sh[7:0]}; end
      3'b100: begin mis = 0;          return sh & 32'hFF; end
      3'b001: begin mis = (off % 2) != 0; return {{16{sh[15]}}, sh[15:0]}; end
      3'b101: begin mis = (off % 2) != 0; return sh & 32'hFFFF; end
      default: begin mis = off != 0;  return w; end
    endcase
  endfunction

  bit          m_busy = 0;
  logic [1:0]  p_off;
  logic [2:0]  p_f3;
  logic [4:0]  p_rd;
  logic        p_rw;
  bit          exp_we = 0, exp_mis = 0, hold_ok = 1;
  logic [4:0]  last_addr = 0;
  logic [31:0] last_data = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; exp_we = 0; exp_mis = 0; hold_ok = 1; last_addr = 0; last_data = 0;
    end else begin
      exp_we = 0; exp_mis = 0;
      if (!m_busy) begin
        if (in_valid) begin
          if (wb_sel == 2'b01) begin
            m_busy = 1; p_off = alu_result[1:0]; p_f3 = funct3; p_rd = rd; p_rw = reg_write;
          end else if (reg_write && rd != 0 && wb_sel != 2'b11) begin
            exp_we = 1; hold_ok = 1; last_addr = rd;
            last_data = (wb_sel == 2'b10) ? pc_plus4 : alu_result;
          end else hold_ok = 0;  // suppressed: port contents unspecified
        end
      end else if (mem_rvalid) begin
        bit mis; logic [31:0] v;
        m_busy = 0;
        v = ld_fmt(p_f3, p_off, mem_rdata, mis);
        if (mis) exp_mis = 1;
        else if (p_rw && p_rd != 0) begin
          exp_we = 1; hold_ok = 1; last_addr = p_rd; last_data = v;
        end else hold_ok = 0;
      end
    end
  end

  // Single compare process: every cycle out of reset.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("m_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("m_we",    {31'd0, rf_we},    {31'd0, exp_we});
      chk("m_mis",   {31'd0, misaligned}, {31'd0, exp_mis});
      if (exp_we || hold_ok) begin
        chk("m_waddr", {27'd0, rf_waddr}, {27'd0, last_addr});
        chk("m_wdata", rf_wdata, last_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] pc, input logic [4:0] r,
                      input logic rw, input logic [1:0] sel, input logic [2:0] f3);
    in_valid = 1; alu_result = a; pc_plus4 = pc; rd = r; reg_write = rw; wb_sel = sel; funct3 = f3;
  endtask

  // Load accepted, response returned the following cycle, check after the write edge.
  task automatic quick_load(input logic [31:0] a, input logic [4:0] r, input logic [2:0] f3,
                            input logic [31:0] w);
    send(a, 0, r, 1, 2'b01, f3);
    @(posedge clk); #1 in_valid = 0; mem_rvalid = 1; mem_rdata = w;
    @(posedge clk); #1 mem_rvalid = 0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; in_valid = 0; alu_result = 0; pc_plus4 = 0; rd = 0; reg_write = 0;
    wb_sel = 0; funct3 = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_waddr", {27'd0, rf_waddr}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_mis", {31'd0, misaligned}, 0);
    chk("rst_ready", {31'd0, in_ready}, 1);
    rst_n = 1;

    // ALU write
    @(negedge clk);
    send(32'h0000_1234, 0, 5, 1, 2'b00, 3'b000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("alu_we", {31'd0, rf_we}, 1);
    chk("alu_waddr", {27'd0, rf_waddr}, 5);
    chk("alu_wdata", rf_wdata, 32'h0000_1234);
    @(negedge clk);
    chk("alu_we_off", {31'd0, rf_we}, 0);

    // LB sign-extend, response 3 cycles after acceptance
    send(32'h0000_0102, 0, 7, 1, 2'b01, 3'b000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk); chk("lb_ready1", {31'd0, in_ready}, 0);
    @(negedge clk); chk("lb_ready2", {31'd0, in_ready}, 0);
    @(negedge clk); chk("lb_ready3", {31'd0, in_ready}, 0);
    mem_rvalid = 1; mem_rdata = 32'h1280_FF00;
    @(posedge clk); #1 mem_rvalid = 0;
    @(negedge clk);
    chk("lb_we", {31'd0, rf_we}, 1);
    chk("lb_waddr", {27'd0, rf_waddr}, 7);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_ready_after", {31'd0, in_ready}, 1);

    // LHU offset 2, LW offset 0, LH offset 2 (sign), LBU offset 3
    quick_load(32'h0000_2002, 9, 3'b101, 32'hBEEF_0000);
    chk("lhu_wdata", rf_wdata, 32'h0000_BEEF);
    chk("lhu_we", {31'd0, rf_we}, 1);
    quick_load(32'h0000_2000, 10, 3'b010, 32'hDEAD_BEEF);
    chk("lw_wdata", rf_wdata, 32'hDEAD_BEEF);
    quick_load(32'h0000_2002, 11, 3'b001, 32'h8001_1234);
    chk("lh_wdata", rf_wdata, 32'hFFFF_8001);
    quick_load(32'h0000_2003, 12, 3'b100, 32'hA5FF_FFFF);
    chk("lbu_wdata", rf_wdata, 32'h0000_00A5);
    quick_load(32'h0000_2000, 13, 3'b111, 32'h0BAD_F00D);
    chk("f3_111_wdata", rf_wdata, 32'h0BAD_F00D);

    // Misaligned LW at offset 1, then LH at offset 3
    quick_load(32'h0000_3001, 3, 3'b010, 32'h1111_2222);
    chk("mis_we", {31'd0, rf_we}, 0);
    chk("mis_pulse", {31'd0, misaligned}, 1);
    chk("mis_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    chk("mis_clear", {31'd0, misaligned}, 0);
    quick_load(32'h0000_3003, 4, 3'b001, 32'h3333_4444);
    chk("mis_lh", {31'd0, misaligned}, 1);

    // mem_rvalid while idle is ignored
    mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 mem_rvalid = 0;
    @(negedge clk);
    chk("idle_rvalid_we", {31'd0, rf_we}, 0);
    chk("idle_rvalid_ready", {31'd0, in_ready}, 1);

    // Suppression: rd=0
    send(32'h0000_0055, 0, 0, 1, 2'b00, 3'b000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("rd0_we", {31'd0, rf_we}, 0);

    // Link value
    send(32'h0000_DEAD, 32'h0000_0104, 1, 1, 2'b10, 3'b000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("link_we", {31'd0, rf_we}, 1);
    chk("link_wdata", rf_wdata, 32'h0000_0104);
    @(negedge clk);
    chk("hold_wdata", rf_wdata, 32'h0000_0104);

    // Back-to-back non-loads, then reg_write=0 and reserved select
    send(32'h0000_0011, 0, 14, 1, 2'b00, 3'b000);
    @(negedge clk);
    chk("b2b1_wdata", rf_wdata, 32'h0000_0011);
    send(32'h0000_0022, 0, 15, 1, 2'b00, 3'b000);
    @(negedge clk);
    chk("b2b2_we", {31'd0, rf_we}, 1);
    chk("b2b2_waddr", {27'd0, rf_waddr}, 15);
    send(32'h0000_0033, 32'h0000_0200, 16, 1, 2'b10, 3'b000);
    @(negedge clk);
    chk("b2b3_wdata", rf_wdata, 32'h0000_0200);
    send(32'h0000_0044, 0, 17, 0, 2'b00, 3'b000);
    @(negedge clk);
    chk("rw0_we", {31'd0, rf_we}, 0);
    send(32'h0000_0055, 0, 18, 1, 2'b11, 3'b000);
    @(negedge clk);
    chk("sel11_we", {31'd0, rf_we}, 0);
    in_valid = 0;
    @(negedge clk);

    // Reset while a load is pending
    send(32'h0000_0000, 0, 4, 1, 2'b01, 3'b010);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("rstld_ready0", {31'd0, in_ready}, 0);
    rst_n = 0;
    #2;
    chk("rstld_async_ready", {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1 mem_rvalid = 0;
    @(negedge clk);
    chk("rstld_we", {31'd0, rf_we}, 0);
    chk("rstld_ready", {31'd0, in_ready}, 1);
    chk("rstld_waddr", {27'd0, rf_waddr}, 0);
    chk("rstld_wdata", rf_wdata, 0);
    chk("rstld_mis", {31'd0, misaligned}, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
